// File: rtl/exp_pwl_pkg.sv
// -----------------------------------------------------------------------------
// exp_pwl_pkg
// Shared helpers for the piecewise-linear exponential pipeline:
//   calc_frac_w    - interpolation fraction width (IN_WIDTH - SEG_BITS)
//   calc_rom_depth - segment endpoint table depth (2^SEG_BITS + 1)
//   exp_entry      - endpoint value k = round(exp(x_k) * 2^OUT_FRAC), evaluated
//                    at elaboration so the table is a constant in the netlist.
// No ports.
// -----------------------------------------------------------------------------
package exp_pwl_pkg;

  // Internal precision of the elaboration-time exp evaluation (fraction bits).
  localparam int EXP_ACC_FRAC = 40;
  localparam int EXP_TERMS    = 40;

  function automatic int calc_frac_w(input int in_width, input int seg_bits);
    return in_width - seg_bits;
  endfunction

  function automatic int calc_rom_depth(input int seg_bits);
    return (1 << seg_bits) + 1;
  endfunction

  // Entry k sits at x_k = (k - 2^(SEG_BITS-1)) * 2^FRAC_W / 2^IN_FRAC.
  // exp(|x|) is summed as a Taylor series in fixed point; negative arguments
  // use the reciprocal so every term stays positive and the series converges fast.
  function automatic longint exp_entry(input int k, input int seg_bits,
                                       input int frac_w, input int in_frac,
                                       input int out_frac, input int out_width);
    longint sum;
    longint term;
    longint num;
    longint den;
    longint mag;
    longint val;
    longint max_val;
    int     half;
    half = 1 << (seg_bits - 1);
    mag  = (k >= half) ? longint'(k - half) : longint'(half - k);
    num  = mag << frac_w;
    den  = longint'(1) << in_frac;
    term = longint'(1) << EXP_ACC_FRAC;
    sum  = term;
    for (int n = 1; n <= EXP_TERMS; n++) begin
      term = (term * num) / (den * longint'(n));
      sum  = sum + term;
    end
    if (k >= half) begin
      val = ((sum << out_frac) + (longint'(1) << (EXP_ACC_FRAC - 1))) >>> EXP_ACC_FRAC;
    end else begin
      val = ((longint'(1) << (EXP_ACC_FRAC + out_frac)) + (sum >>> 1)) / sum;
    end
    max_val = (longint'(1) << out_width) - 1;
    if (val > max_val) begin
      val = max_val;
    end
    return val;
  endfunction

endpackage

// File: rtl/exp_pwl_rom.sv
// -----------------------------------------------------------------------------
// exp_pwl_rom
// Dual-read segment endpoint ROM with registered read. Port A returns
// LUT[idx], port B returns LUT[idx+1]; the table carries one extra entry so
// the top segment reads LUT[2^SEG_BITS] instead of wrapping.
// Ports:
//   i_clk  - clock
//   i_en   - read enable; outputs hold while low (pipeline stall)
//   i_idx  - segment index
//   o_y0   - LUT[idx]   (one cycle after i_en)
//   o_y1   - LUT[idx+1] (one cycle after i_en)
// -----------------------------------------------------------------------------
module exp_pwl_rom
  import exp_pwl_pkg::*;
#(
  parameter int SEG_BITS  = 6,
  parameter int OUT_WIDTH = 16,
  parameter int IN_FRAC   = 8,
  parameter int OUT_FRAC  = 8,
  parameter int FRAC_W    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_en,
  input  logic [SEG_BITS-1:0]  i_idx,
  output logic [OUT_WIDTH-1:0] o_y0,
  output logic [OUT_WIDTH-1:0] o_y1
);

  localparam int DEPTH = calc_rom_depth(SEG_BITS);

  logic [OUT_WIDTH-1:0] rom_mem [DEPTH];
  logic [SEG_BITS:0]    addr0;
  logic [SEG_BITS:0]    addr1;
  logic [OUT_WIDTH-1:0] y0_d;
  logic [OUT_WIDTH-1:0] y1_d;
  logic [OUT_WIDTH-1:0] y0_q;
  logic [OUT_WIDTH-1:0] y1_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam longint ENTRY = exp_entry(gi, SEG_BITS, FRAC_W, IN_FRAC, OUT_FRAC, OUT_WIDTH);
    assign rom_mem[gi] = OUT_WIDTH'(ENTRY);
  end

  always_comb begin
    addr0 = {1'b0, i_idx};
    addr1 = addr0 + (SEG_BITS + 1)'(1);
    y0_d  = rom_mem[addr0];
    y1_d  = rom_mem[addr1];
  end

  // No reset: block-RAM style output registers; validity is tracked by the top.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      y0_q <= y0_d;
      y1_q <= y1_d;
    end
  end

  assign o_y0 = y0_q;
  assign o_y1 = y1_q;

endmodule

// File: rtl/exp_pwl_pipe.sv
// -----------------------------------------------------------------------------
// exp_pwl_pipe
// Three-stage exp(x) evaluator: endpoint lookup, slope*fraction product,
// round-half-up interpolation with saturation. One global advance enable
// freezes every stage when the output is held by the consumer.
// Ports:
//   i_clk, i_rst_n     - clock, asynchronous active-low reset
//   i_valid / o_ready  - input handshake (o_ready = !o_valid || i_ready)
//   i_arg              - signed fixed-point argument (IN_WIDTH, IN_FRAC)
//   i_tag              - sideband returned with the result
//   o_valid / i_ready  - output handshake
//   o_result           - exp(i_arg), unsigned (OUT_WIDTH, OUT_FRAC)
//   o_tag              - tag belonging to o_result
//   o_sat              - result was clipped to 0 or 2^OUT_WIDTH-1
// -----------------------------------------------------------------------------
module exp_pwl_pipe
  import exp_pwl_pkg::*;
#(
  parameter int IN_WIDTH  = 10,
  parameter int IN_FRAC   = 8,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_FRAC  = 8,
  parameter int SEG_BITS  = 6,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [IN_WIDTH-1:0]  i_arg,
  input  logic [TAG_WIDTH-1:0] i_tag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OUT_WIDTH-1:0] o_result,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic                 o_sat
);

  localparam int FRAC_W = calc_frac_w(IN_WIDTH, SEG_BITS);
  localparam int FW     = (FRAC_W > 0) ? FRAC_W : 1;
  localparam int P_W    = OUT_WIDTH + FRAC_W + 1;
  localparam int R_W    = P_W + 1;

  // Payload between the multiply stage and the interpolation stage.
  typedef struct packed {
    logic [OUT_WIDTH-1:0] y0;
    logic [P_W-1:0]       p;
    logic [TAG_WIDTH-1:0] tag;
    logic                 valid;
  } stage_t;

  logic                 en;
  logic [IN_WIDTH-1:0]  u;
  logic [SEG_BITS-1:0]  idx;
  logic [FW-1:0]        frac;

  logic                 v1_d, v1_q;
  logic [TAG_WIDTH-1:0] tag1_d, tag1_q;
  logic [FW-1:0]        frac1_d, frac1_q;
  logic [OUT_WIDTH-1:0] y0_rom, y1_rom;

  logic signed [OUT_WIDTH:0] d;
  logic signed [P_W-1:0]     d_ext, f_ext, p;
  stage_t                    s2_d, s2_q;

  logic signed [R_W-1:0] r;
  logic [OUT_WIDTH-1:0]  res3_d, res3_q;
  logic                  sat3_d, sat3_q;
  logic [TAG_WIDTH-1:0]  tag3_d, tag3_q;
  logic                  v3_d, v3_q;

  assign en      = !v3_q || i_ready;
  assign o_ready = en;

  // Adding 2^(IN_WIDTH-1) to a two's-complement value is an MSB flip.
  assign u   = {~i_arg[IN_WIDTH-1], i_arg[IN_WIDTH-2:0]};
  assign idx = u[IN_WIDTH-1:FRAC_W];

  if (FRAC_W > 0) begin : g_frac
    assign frac = u[FW-1:0];
  end else begin : g_nofrac
    assign frac = '0;
  end

  // ---------------- stage 1: lookup ----------------
  exp_pwl_rom #(
    .SEG_BITS (SEG_BITS),
    .OUT_WIDTH(OUT_WIDTH),
    .IN_FRAC  (IN_FRAC),
    .OUT_FRAC (OUT_FRAC),
    .FRAC_W   (FRAC_W)
  ) u_rom (
    .i_clk(i_clk),
    .i_en (en),
    .i_idx(idx),
    .o_y0 (y0_rom),
    .o_y1 (y1_rom)
  );

  always_comb begin
    v1_d    = v1_q;
    tag1_d  = tag1_q;
    frac1_d = frac1_q;
    if (en) begin
      v1_d    = i_valid;
      tag1_d  = i_tag;
      frac1_d = frac;
    end
  end

  // ---------------- stage 2: slope * fraction ----------------
  always_comb begin
    d     = $signed({1'b0, y1_rom}) - $signed({1'b0, y0_rom});
    d_ext = P_W'(d);
    f_ext = P_W'($signed({1'b0, frac1_q}));
    p     = d_ext * f_ext;
    s2_d  = s2_q;
    if (en) begin
      s2_d.y0    = y0_rom;
      s2_d.p     = p;
      s2_d.tag   = tag1_q;
      s2_d.valid = v1_q;
    end
  end

  // ---------------- stage 3: round, add, clip ----------------
  if (FRAC_W > 0) begin : g_round
    localparam logic signed [P_W-1:0] RND = P_W'(2 ** (FRAC_W - 1));
    logic signed [P_W-1:0] p_rnd;
    assign p_rnd = $signed(s2_q.p) + RND;
    assign r     = R_W'($signed({1'b0, s2_q.y0})) + R_W'(p_rnd >>> FRAC_W);
  end else begin : g_noround
    assign r = R_W'($signed({1'b0, s2_q.y0}));
  end

  always_comb begin
    res3_d = res3_q;
    sat3_d = sat3_q;
    tag3_d = tag3_q;
    v3_d   = v3_q;
    if (en) begin
      tag3_d = s2_q.tag;
      v3_d   = s2_q.valid;
      if (r[R_W-1]) begin
        res3_d = '0;
        sat3_d = 1'b1;
      end else if (|r[R_W-2:OUT_WIDTH]) begin
        res3_d = '1;
        sat3_d = 1'b1;
      end else begin
        res3_d = r[OUT_WIDTH-1:0];
        sat3_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q    <= 1'b0;
      tag1_q  <= '0;
      frac1_q <= '0;
      s2_q    <= '0;
      res3_q  <= '0;
      sat3_q  <= 1'b0;
      tag3_q  <= '0;
      v3_q    <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      tag1_q  <= tag1_d;
      frac1_q <= frac1_d;
      s2_q    <= s2_d;
      res3_q  <= res3_d;
      sat3_q  <= sat3_d;
      tag3_q  <= tag3_d;
      v3_q    <= v3_d;
    end
  end

  assign o_valid  = v3_q;
  assign o_result = res3_q;
  assign o_tag    = tag3_q;
  assign o_sat    = sat3_q;

endmodule

// File: tb/tb_exp_pwl_pipe.sv
// -----------------------------------------------------------------------------
// tb_exp_pwl_pipe
// Scoreboard bench: the driver pushes the expected result of every accepted
// argument; an independent monitor pops and compares on each output handshake.
// Expected values come from real-valued exp() and the interpolation rule.
// -----------------------------------------------------------------------------
module tb_exp_pwl_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [9:0]  i_arg;
  logic [3:0]  i_tag;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [15:0] o_result;
  logic [3:0]  o_tag;
  logic        o_sat;

  typedef struct {
    int res;
    int tag;
    bit sat;
  } exp_t;

  exp_t sb_q[$];
  int   total    = 0;
  int   bad      = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   acc_cnt  = 0;
  int   rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

  exp_pwl_pipe dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_arg   (i_arg),
    .i_tag   (i_tag),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result),
    .o_tag   (o_tag),
    .o_sat   (o_sat)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc = cyc + 1;

  always @(posedge i_clk) begin
    #1;
    case (rdy_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = 1'b0;
      default: i_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  function automatic void chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endfunction

  // Reference: table entry k = round(256 * e^(-2 + k/16)); linear interpolation
  // in 1/16 steps, rounded half up, clipped to 16 bits.
  function automatic int ref_lut(input int k);
    return $rtoi(256.0 * $exp(-2.0 + real'(k) / 16.0) + 0.5);
  endfunction

  function automatic void ref_eval(input logic [9:0] a, output int res, output bit sat);
    int  x;
    int  seg;
    int  fr;
    int  y0;
    int  y1;
    real r;
    x   = $signed(a);
    seg = (x + 512) / 16;
    fr  = (x + 512) % 16;
    y0  = ref_lut(seg);
    y1  = ref_lut(seg + 1);
    r   = real'(y0) + $floor(real'(y1 - y0) * real'(fr) / 16.0 + 0.5);
    sat = 1'b0;
    res = $rtoi(r);
    if (res < 0) begin
      res = 0;
      sat = 1'b1;
    end else if (res > 65535) begin
      res = 65535;
      sat = 1'b1;
    end
  endfunction

  // Called at a falling edge; returns at a falling edge.
  task automatic send(input logic [9:0] a, input logic [3:0] t, input int eres, input bit esat);
    int   n;
    exp_t e;
    n       = 0;
    i_valid = 1'b1;
    i_arg   = a;
    i_tag   = t;
    while (!o_ready && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: arg %03h not accepted after %0d cycles, required acceptance", a, n);
    end else begin
      e.res = eres;
      e.tag = int'(t);
      e.sat = esat;
      sb_q.push_back(e);
      acc_cyc = cyc;
      acc_cnt++;
    end
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic send_m(input logic [9:0] a, input logic [3:0] t);
    int res;
    bit sat;
    ref_eval(a, res, sat);
    send(a, t, res, sat);
  endtask

  task automatic check_latency(input string nm);
    int n;
    n = 0;
    while (!o_valid && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk(nm, cyc - acc_cyc, 3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
    end
  endtask

  // Monitor: handshake scoreboard, ready rule and hold-while-stalled checks.
  initial begin : monitor
    bit          stalled;
    logic [15:0] pres;
    logic [3:0]  ptag;
    logic        psat;
    exp_t        e;
    stalled = 1'b0;
    pres    = '0;
    ptag    = '0;
    psat    = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        stalled = 1'b0;
      end else begin
        chk("ready_rule", o_ready, (!o_valid || i_ready));
        if (stalled) begin
          chk("hold_valid", o_valid, 1);
          chk("hold_result", o_result, pres);
          chk("hold_tag", o_tag, ptag);
          chk("hold_sat", o_sat, psat);
        end
        if (o_valid && i_ready) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: result %04h tag %0h with empty scoreboard, required none", o_result, o_tag);
          end else begin
            e = sb_q.pop_front();
            $display("txn tag=%0h result=%04h sat=%0b (expected %04h)", o_tag, o_result, o_sat, e.res);
            chk("result", o_result, e.res);
            chk("tag", o_tag, e.tag);
            chk("sat", o_sat, e.sat);
          end
        end
        stalled = o_valid && !i_ready;
        pres    = o_result;
        ptag    = o_tag;
        psat    = o_sat;
      end
    end
  end

  initial begin : main
    logic [9:0] stream_args [8];
    stream_args = '{10'h200, 10'h1FF, 10'h000, 10'h008, 10'h0F3, 10'h31C, 10'h17A, 10'h385};
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_arg   = '0;
    i_tag   = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_result", o_result, 0);
    chk("rst_tag", o_tag, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_ready", o_ready, 1);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);

    // Directed points with hand-computed results.
    send(10'h000, 4'h1, 16'h0100, 1'b0);
    check_latency("latency_first");
    send(10'h200, 4'h2, 16'h0023, 1'b0);
    send(10'h1FF, 4'h3, 16'h075D, 1'b0);
    send(10'h008, 4'h4, 16'h0109, 1'b0);
    drain();

    // Tagged stream with a five-cycle downstream stall in the middle.
    begin : stall_test
      int base;
      base = acc_cnt;
      fork
        begin
          for (int i = 0; i < 8; i++) send_m(stream_args[i], 4'(i));
        end
        begin
          int n;
          n = 0;
          while (acc_cnt < base + 4 && n < 200) begin
            @(negedge i_clk);
            n++;
          end
          rdy_mode = 1;
          @(posedge i_clk);
          #2;
          for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            chk("stall_ready", o_ready, 0);
          end
          rdy_mode = 0;
        end
      join
    end
    drain();

    // Reset with three results in flight.
    rdy_mode = 1;
    @(posedge i_clk);
    @(negedge i_clk);
    for (int i = 0; i < 3; i++) send_m(10'(i * 37 + 5), 4'(i + 10));
    begin : wait_full
      int n;
      n = 0;
      while (!o_valid && n < 10) begin
        @(negedge i_clk);
        n++;
      end
    end
    #2;
    i_rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("rst_mid_valid", o_valid, 0);
    chk("rst_mid_ready", o_ready, 1);
    chk("rst_mid_result", o_result, 0);
    rdy_mode = 0;
    repeat (2) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    @(negedge i_clk);
    send(10'h008, 4'h9, 16'h0109, 1'b0);
    check_latency("latency_after_rst");
    drain();

    // Random arguments, tags, gaps and backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
      send_m(10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)));
    end
    rdy_mode = 0;
    drain();

    repeat (4) @(negedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
